// File: rtl/deglitch_filter_mc_pkg.sv
// ---------------------------------------------------------------------------
// deglitch_filter_mc_pkg
//
// Purpose:
//   Shared constants for the multi-channel glitch filter. The same defaults
//   and the minimum effective threshold are used by the filter top level, its
//   per-channel slice and the older single-bit filter bench, so they live in
//   one place.
//
// Contents:
//   DEFAULT_CHANNELS     default number of filtered lines
//   DEFAULT_CNT_W        default stability counter / threshold width
//   DEFAULT_SYNC_STAGES  default synchroniser depth per channel
//   THRESH_MIN           smallest effective threshold (a programmed 0 maps here)
// ---------------------------------------------------------------------------
package deglitch_filter_mc_pkg;

    localparam int DEFAULT_CHANNELS    = 4;
    localparam int DEFAULT_CNT_W       = 4;
    localparam int DEFAULT_SYNC_STAGES = 2;

    // A threshold of zero would mean "flip before the input has been seen",
    // which is meaningless, so the smallest usable threshold is one cycle.
    localparam int THRESH_MIN          = 1;

endpackage : deglitch_filter_mc_pkg

// File: rtl/deglitch_filter_mc_channel.sv
// ---------------------------------------------------------------------------
// deglitch_filter_mc_channel
//
// Purpose:
//   One filtered line. The raw input optionally passes through a synchroniser
//   chain; the filtered output only follows the synchronised level after it
//   has differed from the output for i_teff consecutive enabled cycles.
//   Shorter excursions are dropped. A one-cycle rise or fall strobe is
//   registered on the same edge the output changes.
//
// Ports:
//   i_clk     in   1      rising-edge clock
//   i_rst_n   in   1      synchronous, active-low reset
//   i_enable  in   1      1 = counter/output advance; 0 = frozen, strobes low
//   i_teff    in   CNT_W  effective threshold, already clamped to >= 1
//   i_sig     in   1      raw (possibly asynchronous) input
//   o_sig     out  1      filtered level
//   o_rise    out  1      one-cycle pulse when o_sig goes 0->1
//   o_fall    out  1      one-cycle pulse when o_sig goes 1->0
//   o_flip    out  1      combinational: o_sig will change on the next edge
//                         (lets the parent register an aggregate strobe in
//                         step with o_rise/o_fall)
// ---------------------------------------------------------------------------
module deglitch_filter_mc_channel
    import deglitch_filter_mc_pkg::*;
#(
    parameter int CNT_W       = DEFAULT_CNT_W,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter bit RESET_VAL   = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_enable,
    input  logic [CNT_W-1:0] i_teff,
    input  logic             i_sig,
    output logic             o_sig,
    output logic             o_rise,
    output logic             o_fall,
    output logic             o_flip
);

    logic             w_s;          // synchronised input level
    logic [CNT_W-1:0] r_cnt;        // consecutive cycles w_s has differed
    logic [CNT_W:0]   w_cnt_inc;    // r_cnt + 1, one bit wider so it never wraps
    logic             w_differs;
    logic             w_reach;
    logic             r_out;
    logic             r_rise;
    logic             r_fall;

    // -----------------------------------------------------------------------
    // Input synchroniser. It shifts every cycle, independent of i_enable, so
    // a re-enabled channel always sees a settled, current level.
    // -----------------------------------------------------------------------
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_s = i_sig;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] r_sync;

            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    r_sync <= {SYNC_STAGES{RESET_VAL}};
                end else begin
                    r_sync[0] <= i_sig;
                    for (int k = 1; k < SYNC_STAGES; k++) begin
                        r_sync[k] <= r_sync[k-1];
                    end
                end
            end

            assign w_s = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Stability compare. The increment is evaluated one bit wider than the
    // counter so that cnt = 2**CNT_W-1 cannot wrap to zero and miss the
    // threshold. Using ">=" rather than "==" makes a threshold lowered below
    // the running count take effect on the same edge.
    // -----------------------------------------------------------------------
    assign w_cnt_inc = {1'b0, r_cnt} + (CNT_W+1)'(1);
    assign w_differs = (w_s != r_out);
    assign w_reach   = (w_cnt_inc >= {1'b0, i_teff});
    assign o_flip    = i_enable & w_differs & w_reach;

    // -----------------------------------------------------------------------
    // Counter, filtered output and strobes.
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_out  <= RESET_VAL;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            // Strobes are single-cycle by default; only a flip raises one.
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (i_enable) begin
                if (!w_differs) begin
                    r_cnt <= '0;
                end else if (!w_reach) begin
                    r_cnt <= w_cnt_inc[CNT_W-1:0];
                end else begin
                    r_out  <= w_s;
                    r_cnt  <= '0;
                    r_rise <= w_s;
                    r_fall <= ~w_s;
                end
            end
        end
    end

    assign o_sig  = r_out;
    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule : deglitch_filter_mc_channel

// File: rtl/deglitch_filter_mc.sv
// ---------------------------------------------------------------------------
// deglitch_filter_mc
//
// Purpose:
//   Multi-channel parametrised glitch filter placed between raw asynchronous
//   pins and control logic. Each channel is an independent
//   deglitch_filter_mc_channel instance; this level clamps the shared
//   threshold and registers the aggregate "changed" strobe.
//
// Ports:
//   clock    in   1         rising-edge clock
//   reset    in   1         synchronous, active-low reset
//   enable   in   1         1 = filtering advances; 0 = counters/outputs hold
//   thresh   in   CNT_W     required stable-cycle count; 0 behaves as 1
//   sig_in   in   CHANNELS  raw inputs, may be asynchronous
//   sig_out  out  CHANNELS  filtered levels
//   rise     out  CHANNELS  one-cycle pulse as sig_out[i] goes 0->1
//   fall     out  CHANNELS  one-cycle pulse as sig_out[i] goes 1->0
//   changed  out  1         OR of all rise|fall, same cycle as the strobes
//
// Latency: a step on sig_in that is stable from the first sampling edge
// appears on sig_out at edge SYNC_STAGES + max(thresh,1).
// ---------------------------------------------------------------------------
module deglitch_filter_mc
    import deglitch_filter_mc_pkg::*;
#(
    parameter int CHANNELS    = DEFAULT_CHANNELS,
    parameter int CNT_W       = DEFAULT_CNT_W,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter bit RESET_VAL   = 1'b0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [CNT_W-1:0]    thresh,
    input  logic [CHANNELS-1:0] sig_in,
    output logic [CHANNELS-1:0] sig_out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                changed
);

    logic [CNT_W-1:0]    w_teff;
    logic [CHANNELS-1:0] w_flip;
    logic                r_changed;

    // Threshold is sampled every cycle, so a change takes effect immediately
    // for all channels, including ones that are mid-count.
    assign w_teff = (thresh == '0) ? CNT_W'(THRESH_MIN) : thresh;

    generate
        for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
            deglitch_filter_mc_channel #(
                .CNT_W       (CNT_W),
                .SYNC_STAGES (SYNC_STAGES),
                .RESET_VAL   (RESET_VAL)
            ) u_ch (
                .i_clk    (clock),
                .i_rst_n  (reset),
                .i_enable (enable),
                .i_teff   (w_teff),
                .i_sig    (sig_in[g]),
                .o_sig    (sig_out[g]),
                .o_rise   (rise[g]),
                .o_fall   (fall[g]),
                .o_flip   (w_flip[g])
            );
        end
    endgenerate

    // "changed" is built from each channel's next-edge flip decision rather
    // than from the registered strobes, so it is itself registered yet lands
    // in the same cycle as rise/fall instead of one cycle later.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_changed <= 1'b0;
        end else begin
            r_changed <= |w_flip;
        end
    end

    assign changed = r_changed;

endmodule : deglitch_filter_mc

// File: tb/tb_deglitch_filter_mc.sv
// ---------------------------------------------------------------------------
// tb_deglitch_filter_mc
//
// Bench for deglitch_filter_mc at its default parameters (4 channels,
// 4-bit threshold, 2 sync stages, reset value 0). Every driven cycle runs a
// behavioural reference of the filter and pushes the expected
// {changed, fall, rise, sig_out} word into a queue; a negedge monitor pops
// and compares it with the DUT. Scenario tasks add directed checks on the
// specific edges where something must (or must not) happen.
// ---------------------------------------------------------------------------
module tb_deglitch_filter_mc;

    localparam int CH = 4;

    // ---------------- clock / reset / DUT ----------------
    logic          clock;
    logic          reset;
    logic          enable;
    logic [3:0]    thresh;
    logic [CH-1:0] sig_in;
    logic [CH-1:0] sig_out;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic          changed;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    deglitch_filter_mc dut (
        .clock   (clock),
        .reset   (reset),
        .enable  (enable),
        .thresh  (thresh),
        .sig_in  (sig_in),
        .sig_out (sig_out),
        .rise    (rise),
        .fall    (fall),
        .changed (changed)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [12:0] exp_q[$];

    // reference state
    logic [CH-1:0] m_s0  = '0;
    logic [CH-1:0] m_s1  = '0;
    logic [CH-1:0] m_out = '0;
    int            m_cnt[CH];
    int            m_rise_tot[CH];
    int            m_fall_tot[CH];

    logic [CH-1:0] cur_sig = '0;

    // ---------------- driver: one clock edge ----------------
    // Applies inputs, advances the reference by one edge, queues the expected
    // outputs, then waits until just after the falling edge.
    task automatic drive_cycle(input logic rst_n, input logic en,
                               input logic [3:0] th, input logic [CH-1:0] sig);
        int            teff;
        logic          s;
        logic [CH-1:0] e_rise;
        logic [CH-1:0] e_fall;
        reset  = rst_n;
        enable = en;
        thresh = th;
        sig_in = sig;
        teff   = (th == 4'd0) ? 1 : int'(th);
        e_rise = '0;
        e_fall = '0;
        if (!rst_n) begin
            m_s0  = '0;
            m_s1  = '0;
            m_out = '0;
            for (int c = 0; c < CH; c++) m_cnt[c] = 0;
        end else begin
            for (int c = 0; c < CH; c++) begin
                s = m_s1[c];
                if (en) begin
                    if (s == m_out[c]) begin
                        m_cnt[c] = 0;
                    end else if (m_cnt[c] + 1 < teff) begin
                        m_cnt[c] = m_cnt[c] + 1;
                    end else begin
                        m_out[c] = s;
                        m_cnt[c] = 0;
                        if (s) begin
                            e_rise[c] = 1'b1;
                            m_rise_tot[c]++;
                        end else begin
                            e_fall[c] = 1'b1;
                            m_fall_tot[c]++;
                        end
                    end
                end
            end
            m_s1 = m_s0;
            m_s0 = sig;
        end
        exp_q.push_back({|(e_rise | e_fall), e_fall, e_rise, m_out});
        @(posedge clock);
        @(negedge clock);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clock) begin
        logic [12:0] sb_exp;
        if (exp_q.size() > 0) begin
            sb_exp = exp_q.pop_front();
            n_checks++;
            if ({changed, fall, rise, sig_out} !== sb_exp) begin
                n_fail++;
                $display("FAIL scoreboard t=%0t got chg/fall/rise/out=%b_%b_%b_%b expected %b_%b_%b_%b",
                         $time, changed, fall, rise, sig_out,
                         sb_exp[12], sb_exp[11:8], sb_exp[7:4], sb_exp[3:0]);
            end
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        cur_sig = 4'hF;
        for (int e = 0; e < 3; e++) begin
            drive_cycle(1'b0, 1'b1, 4'd4, cur_sig);
            n_checks++;
            if ({changed, fall, rise, sig_out} !== 13'd0) begin
                n_fail++;
                $display("FAIL reset_hold got %b_%b_%b_%b expected all zero", changed, fall, rise, sig_out);
            end
        end
        drive_cycle(1'b1, 1'b1, 4'd4, cur_sig);
        n_checks++;
        if ({rise, fall, sig_out} !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_release got rise=%b fall=%b out=%b expected 0", rise, fall, sig_out);
        end
        // a one-cycle-long level on the synchronised input must not flip anything
        cur_sig = 4'h0;
        for (int e = 0; e < 8; e++) drive_cycle(1'b1, 1'b1, 4'd4, cur_sig);
        n_checks++;
        if (sig_out !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_settle got out=%b expected 0000", sig_out);
        end
    endtask

    task automatic test_step();
        cur_sig[0] = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            drive_cycle(1'b1, 1'b1, 4'd4, cur_sig);
            if (e == 5) begin
                n_checks++;
                if (sig_out[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL step_early edge5 got out0=%b expected 0", sig_out[0]);
                end
            end
            if (e == 6) begin
                n_checks++;
                if ({sig_out[0], rise[0], fall[0]} !== 3'b110) begin
                    n_fail++;
                    $display("FAIL step_rise edge6 got out/rise/fall=%b%b%b expected 110", sig_out[0], rise[0], fall[0]);
                end
            end
            if (e == 7) begin
                n_checks++;
                if ({sig_out[0], rise[0]} !== 2'b10) begin
                    n_fail++;
                    $display("FAIL step_rise_once edge7 got out/rise=%b%b expected 10", sig_out[0], rise[0]);
                end
            end
        end
        cur_sig[0] = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            drive_cycle(1'b1, 1'b1, 4'd4, cur_sig);
            if (e == 5) begin
                n_checks++;
                if (sig_out[0] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL step_fall_early edge5 got out0=%b expected 1", sig_out[0]);
                end
            end
            if (e == 6) begin
                n_checks++;
                if ({sig_out[0], rise[0], fall[0]} !== 3'b001) begin
                    n_fail++;
                    $display("FAIL step_fall edge6 got out/rise/fall=%b%b%b expected 001", sig_out[0], rise[0], fall[0]);
                end
            end
        end
    endtask

    task automatic test_glitch();
        logic [15:0] pat;
        int          d_rise;
        int          d_fall;
        int          m_r0;
        int          m_f0;
        pat    = 16'b0001_1101_0111_1101;
        d_rise = 0;
        d_fall = 0;
        m_r0   = m_rise_tot[1];
        m_f0   = m_fall_tot[1];
        for (int i = 0; i < 16; i++) begin
            cur_sig[1] = pat[i];
            drive_cycle(1'b1, 1'b1, 4'd3, cur_sig);
            d_rise += int'(rise[1]);
            d_fall += int'(fall[1]);
        end
        cur_sig[1] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1'b1, 1'b1, 4'd3, cur_sig);
            d_rise += int'(rise[1]);
            d_fall += int'(fall[1]);
        end
        // Runs on the line: 1,0,11111,0,1,0,111,000.. -> one rise (5-run), one fall (final 0s)
        n_checks++;
        if (d_rise !== m_rise_tot[1] - m_r0 || d_rise !== 1) begin
            n_fail++;
            $display("FAIL glitch_rise_count got %0d expected %0d", d_rise, m_rise_tot[1] - m_r0);
        end
        n_checks++;
        if (d_fall !== m_fall_tot[1] - m_f0 || d_fall !== 1) begin
            n_fail++;
            $display("FAIL glitch_fall_count got %0d expected %0d", d_fall, m_fall_tot[1] - m_f0);
        end
        n_checks++;
        if (sig_out[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_final got out1=%b expected 0", sig_out[1]);
        end
    endtask

    task automatic test_enable();
        cur_sig[2] = 1'b1;
        // edges 1-2 fill the synchroniser, edges 3-4 count to 2
        for (int e = 1; e <= 4; e++) drive_cycle(1'b1, 1'b1, 4'd4, cur_sig);
        n_checks++;
        if (sig_out[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_precount got out2=%b expected 0", sig_out[2]);
        end
        for (int e = 5; e <= 9; e++) begin
            drive_cycle(1'b1, 1'b0, 4'd4, cur_sig);
            n_checks++;
            if ({sig_out[2], rise, fall, changed} !== 10'd0) begin
                n_fail++;
                $display("FAIL enable_frozen edge%0d got out2=%b rise=%b fall=%b chg=%b expected 0",
                         e, sig_out[2], rise, fall, changed);
            end
        end
        drive_cycle(1'b1, 1'b1, 4'd4, cur_sig);
        n_checks++;
        if (sig_out[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_resume1 got out2=%b expected 0", sig_out[2]);
        end
        drive_cycle(1'b1, 1'b1, 4'd4, cur_sig);
        n_checks++;
        if ({sig_out[2], rise[2], changed} !== 3'b111) begin
            n_fail++;
            $display("FAIL enable_resume2 got out/rise/chg=%b%b%b expected 111", sig_out[2], rise[2], changed);
        end
        drive_cycle(1'b1, 1'b1, 4'd4, cur_sig);
        n_checks++;
        if ({rise[2], changed} !== 2'b00) begin
            n_fail++;
            $display("FAIL enable_strobe_once got rise/chg=%b%b expected 00", rise[2], changed);
        end
    endtask

    task automatic test_thresh();
        cur_sig[3] = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            drive_cycle(1'b1, 1'b1, 4'd0, cur_sig);
            n_checks++;
            if (e < 3 && sig_out[3] !== 1'b0) begin
                n_fail++;
                $display("FAIL thresh0_early edge%0d got out3=%b expected 0", e, sig_out[3]);
            end else if (e == 3 && {sig_out[3], rise[3]} !== 2'b11) begin
                n_fail++;
                $display("FAIL thresh0_flip edge3 got out/rise=%b%b expected 11", sig_out[3], rise[3]);
            end
        end
        cur_sig[3] = 1'b0;
        // thresh 8: sync on edges 1-2, count reaches 3 on edge 5
        for (int e = 1; e <= 5; e++) drive_cycle(1'b1, 1'b1, 4'd8, cur_sig);
        n_checks++;
        if (sig_out[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL thresh_lower_pre got out3=%b expected 1", sig_out[3]);
        end
        drive_cycle(1'b1, 1'b1, 4'd2, cur_sig);
        n_checks++;
        if ({sig_out[3], fall[3]} !== 2'b01) begin
            n_fail++;
            $display("FAIL thresh_lower_flip got out/fall=%b%b expected 01", sig_out[3], fall[3]);
        end
    endtask

    task automatic test_multi();
        // present state is out=0100; drive every channel to the opposite level
        cur_sig = 4'b1011;
        for (int e = 1; e <= 7; e++) begin
            drive_cycle(1'b1, 1'b1, 4'd4, cur_sig);
            if (e == 5) begin
                n_checks++;
                if ({changed, sig_out} !== 5'b0_0100) begin
                    n_fail++;
                    $display("FAIL multi_pre got chg/out=%b_%b expected 0_0100", changed, sig_out);
                end
            end
            if (e == 6) begin
                n_checks++;
                if ({changed, fall, rise, sig_out} !== 13'b1_0100_1011_1011) begin
                    n_fail++;
                    $display("FAIL multi_flip got %b_%b_%b_%b expected 1_0100_1011_1011",
                             changed, fall, rise, sig_out);
                end
            end
            if (e == 7) begin
                n_checks++;
                if ({changed, fall, rise} !== 9'd0) begin
                    n_fail++;
                    $display("FAIL multi_once got chg/fall/rise=%b_%b_%b expected 0", changed, fall, rise);
                end
            end
        end
        // start counting back, then reset in the middle of the count
        cur_sig = 4'b0100;
        for (int e = 1; e <= 4; e++) drive_cycle(1'b1, 1'b1, 4'd4, cur_sig);
        cur_sig = 4'hF;
        drive_cycle(1'b0, 1'b1, 4'd4, cur_sig);
        n_checks++;
        if ({changed, fall, rise, sig_out} !== 13'd0) begin
            n_fail++;
            $display("FAIL multi_reset got %b_%b_%b_%b expected all zero", changed, fall, rise, sig_out);
        end
        // a cleared counter means the full 2+4 edges are needed again
        for (int e = 1; e <= 6; e++) begin
            drive_cycle(1'b1, 1'b1, 4'd4, cur_sig);
            if (e == 5) begin
                n_checks++;
                if ({changed, rise, sig_out} !== 9'd0) begin
                    n_fail++;
                    $display("FAIL multi_post_reset_early got chg/rise/out=%b_%b_%b expected 0", changed, rise, sig_out);
                end
            end
            if (e == 6) begin
                n_checks++;
                if ({changed, rise, sig_out} !== 9'b1_1111_1111) begin
                    n_fail++;
                    $display("FAIL multi_post_reset_flip got chg/rise/out=%b_%b_%b expected 1_1111_1111",
                             changed, rise, sig_out);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] th;
        logic       en;
        logic       rst_n;
        th = 4'd2;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 15) == 0) th = 4'($urandom_range(0, 6));
            en    = ($urandom_range(0, 9) != 0);
            rst_n = ($urandom_range(0, 99) != 0);
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 4) == 0) cur_sig[c] = ~cur_sig[c];
            end
            drive_cycle(rst_n, en, th, cur_sig);
        end
        for (int n = 0; n < 12; n++) drive_cycle(1'b1, 1'b1, th, cur_sig);
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        reset  = 1'b0;
        enable = 1'b1;
        thresh = 4'd4;
        sig_in = '0;
        for (int c = 0; c < CH; c++) begin
            m_cnt[c]      = 0;
            m_rise_tot[c] = 0;
            m_fall_tot[c] = 0;
        end
        test_reset();
        test_step();
        test_glitch();
        test_enable();
        test_thresh();
        test_multi();
        test_random();
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_deglitch_filter_mc
